// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch unit for the 4-bit CPU. It owns the program counter.
// On a fetch request it reads one instruction as four nibbles from a
// nibble-wide synchronous program ROM. It then presents the assembled frame
// to the control FSM.
//
// Ports
//   clk          system clock, rising-edge active
//   rst          asynchronous, active-low reset
//   pc_inc_en    advance pc by one instruction
//   pc_set_en    load pc from jump_addr (wins over pc_inc_en)
//   jump_addr    jump target (instruction index)
//   mem_en       fetch request, honoured only when no fetch is pending
//   mem_rd       ROM read strobe
//   mem_addr     ROM nibble address {base, idx}, zero when mem_rd is low
//   mem_rdata    ROM data, valid the cycle after the mem_rd cycle
//   data_frame   last complete instruction {opcode, raddr0, waddr, imm}
//   frame_valid  one-cycle pulse when data_frame has just been updated
//   busy         fetch in progress
//   pc           current program counter
// ---------------------------------------------------------------------------
module instr_fetch #(
  parameter int CAP  = 4,
  parameter int PC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pc_inc_en,
  input  logic             pc_set_en,
  input  logic [PC_W-1:0]  jump_addr,
  input  logic             mem_en,
  output logic             mem_rd,
  output logic [PC_W+1:0]  mem_addr,
  input  logic [CAP-1:0]   mem_rdata,
  output logic [4*CAP-1:0] data_frame,
  output logic             frame_valid,
  output logic             busy,
  output logic [PC_W-1:0]  pc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          idx_q, idx_d;
  logic [PC_W-1:0]     base_q, base_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic                capVld_q;
  logic [1:0]          capIdx_q;
  logic [0:3][CAP-1:0] shadow_q, shadow_d;
  logic [4*CAP-1:0]    frame_q, frame_d;
  logic                frameValid_q;
  logic                frameLoad;

  // Program counter: a jump overrides an increment; the increment wraps
  // naturally at 2^PC_W. Independent of the fetch state machine.
  always_comb begin
    pc_d = pc_q;
    if (pc_set_en) begin
      pc_d = jump_addr;
    end else if (pc_inc_en) begin
      pc_d = pc_q + PC_W'(1);
    end
  end

  // Fetch sequencing. WAIT is the final cycle of a fetch: the frame is
  // published on its exit edge, and a pending request is accepted on that
  // same edge so back-to-back fetches run at one frame every five cycles.
  // The base is taken from the pre-update pc so a same-edge pc change does
  // not affect which instruction is fetched.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    base_d    = base_q;
    frameLoad = 1'b0;
    mem_rd    = 1'b0;
    mem_addr  = '0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_en) begin
          base_d  = pc_q;
          idx_d   = 2'd0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        busy     = 1'b1;
        mem_rd   = 1'b1;
        mem_addr = {base_q, idx_q};
        idx_d    = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        busy      = 1'b1;
        frameLoad = 1'b1;
        state_d   = IDLE;
        if (mem_en) begin
          base_d  = pc_q;
          idx_d   = 2'd0;
          state_d = ISSUE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Each read's data arrives one cycle after its strobe, so the slot to
  // fill is the index issued in the previous cycle. The published frame
  // is taken from shadow_d so the final nibble, captured on the same edge,
  // is already included.
  always_comb begin
    shadow_d = shadow_q;
    if (capVld_q) begin
      shadow_d[capIdx_q] = mem_rdata;
    end
    frame_d = frameLoad ? shadow_d : frame_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      idx_q        <= 2'd0;
      base_q       <= '0;
      pc_q         <= '0;
      capVld_q     <= 1'b0;
      capIdx_q     <= 2'd0;
      shadow_q     <= '0;
      frame_q      <= '0;
      frameValid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      base_q       <= base_d;
      pc_q         <= pc_d;
      capVld_q     <= mem_rd;
      capIdx_q     <= idx_q;
      shadow_q     <= shadow_d;
      frame_q      <= frame_d;
      frameValid_q <= frameLoad;
    end
  end

  assign data_frame  = frame_q;
  assign frame_valid = frameValid_q;
  assign pc          = pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
//
// Self-checking bench for instr_fetch. It contains a synchronous nibble ROM
// model, a directed vector table, hand-written corner-case sequences, and a
// randomized phase. The randomized phase is checked against a
// transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

  localparam int CAP  = 4;
  localparam int PC_W = 8;

  logic             clk;
  logic             rst;
  logic             pc_inc_en;
  logic             pc_set_en;
  logic [PC_W-1:0]  jump_addr;
  logic             mem_en;
  logic             mem_rd;
  logic [PC_W+1:0]  mem_addr;
  logic [CAP-1:0]   mem_rdata;
  logic [4*CAP-1:0] data_frame;
  logic             frame_valid;
  logic             busy;
  logic [PC_W-1:0]  pc;

  logic [CAP-1:0] rom [0:1023];

  int nCompared   = 0;
  int nMismatched = 0;

  // Reference model state. A fetch is described by the edge that accepted
  // it and its base. Everything else follows from the timing rules:
  // reads go out in cycles 1-4, and the frame appears after edge 5.
  int          edgeNo;
  int          fetchStart;
  logic [7:0]  mPc;
  logic [7:0]  mBase;
  logic [15:0] mFrame;
  logic        mValid;

  typedef struct {
    logic        inc;
    logic        set;
    logic [7:0]  jaddr;
    logic        en;
    logic [7:0]  expPc;
    logic        expBusy;
    logic        expRd;
    logic [9:0]  expAddr;
    logic        expValid;
    logic [15:0] expFrame;
  } vec_t;

  vec_t vecs [13];

  instr_fetch #(.CAP(CAP), .PC_W(PC_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_inc_en  (pc_inc_en),
    .pc_set_en  (pc_set_en),
    .jump_addr  (jump_addr),
    .mem_en     (mem_en),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .data_frame (data_frame),
    .frame_valid(frame_valid),
    .busy       (busy),
    .pc         (pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous ROM. When no read is issued, the output is scrambled, so
  // a capture taken on the wrong cycle picks up garbage.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= rom[mem_addr];
    else        mem_rdata <= CAP'($urandom);
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [15:0] romFrame(input logic [7:0] b);
    return {rom[{b, 2'd0}], rom[{b, 2'd1}], rom[{b, 2'd2}], rom[{b, 2'd3}]};
  endfunction

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s (edge %0d): got %0h, want %0h", name, edgeNo, act, exp);
    end
  endtask

  task automatic modelReset();
    fetchStart = -1;
    mPc        = 8'h00;
    mBase      = 8'h00;
    mFrame     = 16'h0000;
    mValid     = 1'b0;
  endtask

  task automatic modelEdge(input logic inc, input logic set, input logic [7:0] ja, input logic en);
    edgeNo++;
    mValid = 1'b0;
    if (fetchStart >= 0 && edgeNo - fetchStart == 5) begin
      mFrame = romFrame(mBase);
      mValid = 1'b1;
    end
    if (en && (fetchStart < 0 || edgeNo - fetchStart >= 5)) begin
      fetchStart = edgeNo;
      mBase      = mPc;
    end
    if (set)      mPc = ja;
    else if (inc) mPc = mPc + 8'd1;
  endtask

  // Drive one cycle of inputs, advance one clock, update the model, and
  // settle just past the edge.
  task automatic applyStimulus(input logic inc, input logic set, input logic [7:0] ja, input logic en);
    pc_inc_en = inc;
    pc_set_en = set;
    jump_addr = ja;
    mem_en    = en;
    @(posedge clk);
    modelEdge(inc, set, ja, en);
    #1;
  endtask

  task automatic checkOutput();
    int         c;
    logic       eBusy;
    logic       eRd;
    logic [9:0] eAddr;
    c     = edgeNo - fetchStart + 1;
    eBusy = (fetchStart >= 0) && (c >= 1) && (c <= 5);
    eRd   = (fetchStart >= 0) && (c >= 1) && (c <= 4);
    eAddr = eRd ? {mBase, 2'(c - 1)} : 10'd0;
    checkEq("pc",          32'(pc),          32'(mPc));
    checkEq("busy",        32'(busy),        32'(eBusy));
    checkEq("mem_rd",      32'(mem_rd),      32'(eRd));
    checkEq("mem_addr",    32'(mem_addr),    32'(eAddr));
    checkEq("frame_valid", 32'(frame_valid), 32'(mValid));
    checkEq("data_frame",  32'(data_frame),  32'(mFrame));
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
      checkOutput();
    end
  endtask

  initial begin
    int          fvCount;
    int          fvTimes[$];
    logic [15:0] expF;
    logic        inc;
    logic        set;
    logic        en;
    logic [7:0]  ja;

    for (int i = 0; i < 1024; i++) rom[i] = CAP'($urandom_range(0, 15));
    rom[0] = 4'h3; rom[1] = 4'hA; rom[2] = 4'hB; rom[3] = 4'hF;

    //            inc   set   jaddr  en    pc     busy  rd    addr   fv    frame
    vecs[0]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 10'd0, 1'b0, 16'h0000};
    vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 10'd1, 1'b0, 16'h0000};
    vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 10'd2, 1'b0, 16'h0000};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 10'd3, 1'b0, 16'h0000};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 10'd0, 1'b0, 16'h0000};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 10'd0, 1'b1, 16'h3ABF};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 10'd0, 1'b0, 16'h3ABF};
    vecs[7]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0, 10'd0, 1'b0, 16'h3ABF};
    vecs[8]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h02, 1'b0, 1'b0, 10'd0, 1'b0, 16'h3ABF};
    vecs[9]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h03, 1'b0, 1'b0, 10'd0, 1'b0, 16'h3ABF};
    vecs[10] = '{1'b1, 1'b1, 8'h40, 1'b0, 8'h40, 1'b0, 1'b0, 10'd0, 1'b0, 16'h3ABF};
    vecs[11] = '{1'b0, 1'b1, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b0, 10'd0, 1'b0, 16'h3ABF};
    vecs[12] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 10'd0, 1'b0, 16'h3ABF};

    // Reset values, checked while reset is held
    edgeNo    = 0;
    modelReset();
    pc_inc_en = 1'b0;
    pc_set_en = 1'b0;
    jump_addr = 8'h00;
    mem_en    = 1'b0;
    rst       = 1'b1;
    #2 rst = 1'b0;
    #1;
    checkEq("reset pc",          32'(pc),          32'd0);
    checkEq("reset data_frame",  32'(data_frame),  32'd0);
    checkEq("reset frame_valid", 32'(frame_valid), 32'd0);
    checkEq("reset busy",        32'(busy),        32'd0);
    checkEq("reset mem_rd",      32'(mem_rd),      32'd0);
    checkEq("reset mem_addr",    32'(mem_addr),    32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;

    // Directed table: first fetch, then pc control
    $display("[TB] directed vector table");
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].inc, vecs[i].set, vecs[i].jaddr, vecs[i].en);
      checkEq($sformatf("vec%0d pc", i),          32'(pc),          32'(vecs[i].expPc));
      checkEq($sformatf("vec%0d busy", i),        32'(busy),        32'(vecs[i].expBusy));
      checkEq($sformatf("vec%0d mem_rd", i),      32'(mem_rd),      32'(vecs[i].expRd));
      checkEq($sformatf("vec%0d mem_addr", i),    32'(mem_addr),    32'(vecs[i].expAddr));
      checkEq($sformatf("vec%0d frame_valid", i), 32'(frame_valid), 32'(vecs[i].expValid));
      checkEq($sformatf("vec%0d data_frame", i),  32'(data_frame),  32'(vecs[i].expFrame));
    end

    // Base latching against a same-edge increment and a mid-fetch jump
    $display("[TB] base latching");
    applyStimulus(1'b0, 1'b1, 8'h05, 1'b0);
    checkOutput();
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    checkOutput();
    checkEq("latch pc after inc", 32'(pc),       32'h06);
    checkEq("latch addr0",        32'(mem_addr), 32'd20);
    applyStimulus(1'b0, 1'b1, 8'h10, 1'b0);
    checkOutput();
    checkEq("latch pc after jump", 32'(pc),       32'h10);
    checkEq("latch addr1",         32'(mem_addr), 32'd21);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput();
    checkEq("latch addr2", 32'(mem_addr), 32'd22);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput();
    checkEq("latch addr3", 32'(mem_addr), 32'd23);
    idleCycles(2);
    expF = {rom[20], rom[21], rom[22], rom[23]};
    checkEq("latch frame", 32'(data_frame), 32'(expF));

    // Busy rejection: a second request in cycle 3 is dropped
    $display("[TB] busy rejection");
    idleCycles(2);
    fvCount = 0;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput();
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, k == 3);
      checkOutput();
      if (frame_valid) fvCount++;
      if (k >= 5) checkEq($sformatf("reject busy after edge %0d", k), 32'(busy), 32'd0);
    end
    checkEq("reject frame_valid count", 32'(fvCount), 32'd1);

    // Back-to-back fetches with pc held at 2
    $display("[TB] back-to-back");
    applyStimulus(1'b0, 1'b1, 8'h02, 1'b0);
    checkOutput();
    fvTimes.delete();
    expF = {rom[8], rom[9], rom[10], rom[11]};
    for (int k = 0; k < 14; k++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, k < 10);
      checkOutput();
      if (frame_valid) begin
        fvTimes.push_back(k);
        checkEq("b2b frame", 32'(data_frame), 32'(expF));
      end
    end
    checkEq("b2b pulse count", 32'(fvTimes.size()), 32'd2);
    if (fvTimes.size() >= 2) checkEq("b2b pulse spacing", 32'(fvTimes[1] - fvTimes[0]), 32'd5);

    // Randomized traffic against the reference model
    $display("[TB] randomized phase");
    for (int k = 0; k < 300; k++) begin
      inc = ($urandom_range(0, 99) < 30);
      set = ($urandom_range(0, 99) < 10);
      ja  = 8'($urandom);
      en  = ($urandom_range(0, 99) < 40);
      applyStimulus(inc, set, ja, en);
      checkOutput();
    end
    idleCycles(6);

    // Reset during cycle 3 of a fetch
    $display("[TB] reset mid-fetch");
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    checkOutput();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput();
    idleCycles(5);
    applyStimulus(1'b0, 1'b1, 8'h33, 1'b0);
    checkOutput();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput();
    idleCycles(2);
    #2 rst = 1'b0;
    #1;
    checkEq("midreset mem_rd",     32'(mem_rd),      32'd0);
    checkEq("midreset mem_addr",   32'(mem_addr),    32'd0);
    checkEq("midreset busy",       32'(busy),        32'd0);
    checkEq("midreset data_frame", 32'(data_frame),  32'd0);
    checkEq("midreset pc",         32'(pc),          32'd0);
    checkEq("midreset fv",         32'(frame_valid), 32'd0);
    modelReset();
    @(posedge clk);
    #1 rst = 1'b1;
    idleCycles(8);
    applyStimulus(1'b0, 1'b1, 8'h07, 1'b0);
    checkOutput();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput();
    idleCycles(4);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput();
    checkEq("post-reset fv",    32'(frame_valid), 32'd1);
    checkEq("post-reset frame", 32'(data_frame),  32'(romFrame(8'h07)));
    idleCycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
